controller_op_reducer: RTL
==========================

# controller_op_reducer

Parametrised operator stack with precedence-driven reduction for the calculator controller. It implements the operator half of the shunting-yard evaluator. It accepts operator tokens from the controller and pops and issues higher-or-equal-precedence operators to the ALU sequencer over a valid/ready handshake. It then pushes the new operator and handles parentheses. On request it flushes the whole stack. Stack depth, operator width and precedence width are parameters.

## Interface
- `OP_W`, default 4: operator code width.
- `DEPTH`, default 8: stack entries, power of two not required, ≥2.
- `PREC_W`, default 2: precedence rank width.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: reset, synchronous, active-low.
- `in_op` in `OP_W`: operator token.
- `in_valid` in 1: token valid.
- `in_ready` out 1: block can accept a token or flush.
- `flush` in 1: evaluate-all request (`=`), sampled when `in_ready`; takes priority over `in_valid`.
- `issue_op` out `OP_W`: operator to ALU sequencer.
- `issue_valid` out 1: issue_op valid.
- `issue_ready` in 1: sequencer consumed issue_op.
- `done` out 1: one-cycle pulse on flush completion.
- `err` out 2: sticky error: 0 none, 1 overflow, 2 paren mismatch.
- `level` out `$clog2(DEPTH+1)`: current entry count.

## Operation
- States: IDLE, REDUCE, PUSH, FLUSH, ERROR.
- In IDLE, `in_ready`=1.
- IDLE → FLUSH when `flush`=1.
- Otherwise IDLE → REDUCE when `in_valid`=1; `in_op` is latched into `held`.
- REDUCE (held is an arithmetic op):
  - If the stack is non-empty, top ≠ LP, and prec(top) ≥ prec(held), drive `issue_op`=top and `issue_valid`=1.
  - On `issue_ready`, pop and re-evaluate next cycle.
  - Otherwise → PUSH.
- REDUCE when held = LP: go straight to PUSH.
- REDUCE when held = RP:
  - Issue and pop until top = LP.
  - Then pop the LP without issuing, discard RP, → IDLE.
  - If the stack empties first → ERROR (err=2).
- PUSH:
  - If `level`=DEPTH → ERROR (err=1); the op is dropped.
  - Else write held, increment level, → IDLE.
- FLUSH:
  - Issue and pop each top until empty, then pulse `done` and → IDLE.
  - An LP found during flush → ERROR (err=2); the stack is cleared.
- ERROR:
  - `in_ready`=0, `issue_valid`=0; the stack is cleared on entry.
  - Exit only via Reset.
- Token NO (code 0) in IDLE is ignored: accepted, no state change.

## Timing
- All outputs registered from state/stack; no combinational input→output path except `in_ready`, which is decoded from state.
- Reset values: state IDLE, level 0, issue_valid 0, issue_op 0, done 0, err 0. `in_ready`=0 while Reset is low and 1 the first cycle after release.
- Handshake:
  - `issue_valid` and `issue_op` remain stable until a cycle with `issue_ready`=1.
  - Transfer occurs on the edge where both are high.
  - Next issue is no earlier than the following cycle.
- Latency:
  - Token accept → push completes in 2 cycles with no reduction: REDUCE evaluates one cycle, PUSH writes the next.
  - Each issued operator adds ≥1 cycle.
- Flush with N entries and `issue_ready` tied high: `done` is asserted N+1 cycles after `flush` is accepted; with an empty stack, 1 cycle.
- Reset low mid-operation: the next edge forces IDLE, empties the stack and drops `issue_valid` even mid-handshake.
- `in_valid` and `flush` while `in_ready`=0 are ignored; they are not queued.

## Structure
- Operator codes and precedence go in `CONT_INTERNAL.v`:
  - Codes: `CO_NO`=0, `CO_ADD`=1, `CO_SUB`=2, `CO_MUL`=3, `CO_DIV`=4, `CO_LP`=5, `CO_RP`=6.
  - Precedence: ADD/SUB 1, MUL/DIV 2, LP 0.
  - State encodings `CR_*` also go here.
- Sub-module `op_precedence`: combinational code→rank lookup, instantiated twice (top, held).
- Stack is a register array with a level pointer; no memory macro.

## Test plan
- Push ADD(1), then MUL(3) → no issue; level=2; each accept→IDLE takes 2 cycles.
- Stack [ADD,MUL], send SUB(2) → issue MUL then ADD, then push SUB; level=1.
- Send LP, ADD, RP with `issue_ready` low for 3 cycles → `issue_valid` holds ADD stable 3 cycles; after release, level=0.
- Stack [ADD,MUL,SUB], flush with `issue_ready`=1 → issue SUB, MUL, ADD on consecutive cycles; `done` pulses at cycle 4.
- DEPTH=8, push 9 LPs → err=1, `in_ready`=0; RP on an empty stack after reset → err=2.
- Reset low during an issue handshake → `issue_valid`=0, level=0, state IDLE next cycle.

Source files
------------

// File: rtl/controller_op_reducer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controller_op_reducer_pkg
//  Description : Operator codes, precedence ranks, error codes and controller
//                state encodings shared by the operator-reducer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package controller_op_reducer_pkg;

    // Operator token codes
    localparam int unsigned CO_NO  = 0;
    localparam int unsigned CO_ADD = 1;
    localparam int unsigned CO_SUB = 2;
    localparam int unsigned CO_MUL = 3;
    localparam int unsigned CO_DIV = 4;
    localparam int unsigned CO_LP  = 5;
    localparam int unsigned CO_RP  = 6;

    // Precedence ranks (LP ranks lowest so it never reduces)
    localparam int unsigned PREC_LP     = 0;
    localparam int unsigned PREC_ADDSUB = 1;
    localparam int unsigned PREC_MULDIV = 2;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_PAREN    = 2'd2;

    // Controller states
    typedef enum logic [2:0] {
        CR_IDLE   = 3'd0,
        CR_REDUCE = 3'd1,
        CR_PUSH   = 3'd2,
        CR_FLUSH  = 3'd3,
        CR_ERROR  = 3'd4
    } cr_state_e;

endpackage
`default_nettype wire

// File: rtl/controller_op_reducer_op_precedence.sv
`default_nettype none
// ============================================================================
//  Module      : op_precedence
//  Description : Combinational operator-code to precedence-rank lookup.
//                Non-arithmetic codes (NO, LP, RP, unknown) rank 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module op_precedence #(
    parameter int OP_W   = 4,
    parameter int PREC_W = 2
) (
    input  logic [OP_W-1:0]   op,
    output logic [PREC_W-1:0] prec
);
    import controller_op_reducer_pkg::*;

    // Map operator code to its binding strength
    always_comb begin
        prec = PREC_W'(PREC_LP);
        if (op == OP_W'(CO_ADD) || op == OP_W'(CO_SUB)) begin
            prec = PREC_W'(PREC_ADDSUB);
        end else if (op == OP_W'(CO_MUL) || op == OP_W'(CO_DIV)) begin
            prec = PREC_W'(PREC_MULDIV);
        end
    end

endmodule
`default_nettype wire

// File: rtl/controller_op_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : controller_op_reducer
//  Description : Operator stack of the shunting-yard evaluator. Reduces
//                higher-or-equal precedence operators to the ALU sequencer
//                over valid/ready, pushes new operators, matches parentheses
//                and flushes the whole stack on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module controller_op_reducer #(
    parameter int OP_W   = 4,
    parameter int DEPTH  = 8,
    parameter int PREC_W = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [OP_W-1:0]              in_op,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [OP_W-1:0]              issue_op,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic                         done,
    output logic [1:0]                   err,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    import controller_op_reducer_pkg::*;

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    cr_state_e         state;
    cr_state_e         state_next;
    logic [OP_W-1:0]   stack [DEPTH];
    logic [OP_W-1:0]   held;
    logic              hold_load;
    logic              push_en;
    logic [LW-1:0]     level_next;
    logic [LW-1:0]     level_m1;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     next_idx;
    logic [OP_W-1:0]   top_op;
    logic [OP_W-1:0]   next_op;
    logic [PREC_W-1:0] prec_top;
    logic [PREC_W-1:0] prec_held;
    logic              issue_valid_next;
    logic [OP_W-1:0]   issue_op_next;
    logic              done_next;
    logic [1:0]        err_next;
    logic              nonempty;
    logic              xfer;
    logic              top_is_lp;
    logic              held_lp;
    logic              held_rp;
    logic              held_arith;

    // Top-of-stack and the entry beneath it (the latter lets a flush issue
    // back-to-back without a bubble). Reads are only used when level covers them.
    assign level_m1  = level - LW'(1);
    assign top_idx   = IW'(level - LW'(1));
    assign next_idx  = IW'(level - LW'(2));
    assign top_op    = stack[top_idx];
    assign next_op   = stack[next_idx];
    assign nonempty  = (level != '0);
    assign xfer      = issue_valid & issue_ready;
    assign top_is_lp = (top_op == OP_W'(CO_LP));

    assign held_lp    = (held == OP_W'(CO_LP));
    assign held_rp    = (held == OP_W'(CO_RP));
    assign held_arith = (held == OP_W'(CO_ADD)) || (held == OP_W'(CO_SUB)) ||
                        (held == OP_W'(CO_MUL)) || (held == OP_W'(CO_DIV));

    // Ready is a pure state decode, held low while reset is asserted
    assign in_ready = Reset & (state == CR_IDLE);

    op_precedence #(.OP_W(OP_W), .PREC_W(PREC_W)) u_prec_top (
        .op   (top_op),
        .prec (prec_top)
    );

    op_precedence #(.OP_W(OP_W), .PREC_W(PREC_W)) u_prec_held (
        .op   (held),
        .prec (prec_held)
    );

    // Next-state and next-output decode
    always_comb begin
        state_next       = state;
        level_next       = level;
        issue_valid_next = issue_valid;
        issue_op_next    = issue_op;
        done_next        = 1'b0;
        err_next         = err;
        push_en          = 1'b0;
        hold_load        = 1'b0;
        case (state)
            CR_IDLE: begin
                if (flush) begin
                    state_next = CR_FLUSH;
                end else if (in_valid && in_op != OP_W'(CO_NO)) begin
                    hold_load  = 1'b1;
                    state_next = CR_REDUCE;
                end
            end
            CR_REDUCE: begin
                if (xfer) begin
                    // Pop the consumed operator; re-evaluate next cycle
                    issue_valid_next = 1'b0;
                    level_next       = level_m1;
                end else if (issue_valid) begin
                    state_next = CR_REDUCE;
                end else if (held_lp) begin
                    state_next = CR_PUSH;
                end else if (held_rp) begin
                    if (!nonempty) begin
                        state_next = CR_ERROR;
                        err_next   = ERR_PAREN;
                        level_next = '0;
                    end else if (top_is_lp) begin
                        // Matching LP is dropped silently, RP is discarded
                        level_next = level_m1;
                        state_next = CR_IDLE;
                    end else begin
                        issue_valid_next = 1'b1;
                        issue_op_next    = top_op;
                    end
                end else if (held_arith) begin
                    if (nonempty && !top_is_lp && prec_top >= prec_held) begin
                        issue_valid_next = 1'b1;
                        issue_op_next    = top_op;
                    end else begin
                        state_next = CR_PUSH;
                    end
                end else begin
                    // Unknown codes are dropped
                    state_next = CR_IDLE;
                end
            end
            CR_PUSH: begin
                if (level == LW'(DEPTH)) begin
                    state_next = CR_ERROR;
                    err_next   = ERR_OVERFLOW;
                    level_next = '0;
                end else begin
                    push_en    = 1'b1;
                    level_next = level + LW'(1);
                    state_next = CR_IDLE;
                end
            end
            CR_FLUSH: begin
                if (!issue_valid) begin
                    if (!nonempty) begin
                        done_next  = 1'b1;
                        state_next = CR_IDLE;
                    end else if (top_is_lp) begin
                        state_next = CR_ERROR;
                        err_next   = ERR_PAREN;
                        level_next = '0;
                    end else begin
                        issue_valid_next = 1'b1;
                        issue_op_next    = top_op;
                    end
                end else if (issue_ready) begin
                    level_next = level_m1;
                    if (level == LW'(1)) begin
                        issue_valid_next = 1'b0;
                        done_next        = 1'b1;
                        state_next       = CR_IDLE;
                    end else if (next_op == OP_W'(CO_LP)) begin
                        issue_valid_next = 1'b0;
                        state_next       = CR_ERROR;
                        err_next         = ERR_PAREN;
                        level_next       = '0;
                    end else begin
                        issue_op_next = next_op;
                    end
                end
            end
            CR_ERROR: begin
                issue_valid_next = 1'b0;
                level_next       = '0;
            end
            default: begin
                state_next = CR_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= CR_IDLE;
            level       <= '0;
            issue_valid <= 1'b0;
            issue_op    <= '0;
            done        <= 1'b0;
            err         <= ERR_NONE;
        end else begin
            state       <= state_next;
            level       <= level_next;
            issue_valid <= issue_valid_next;
            issue_op    <= issue_op_next;
            done        <= done_next;
            err         <= err_next;
        end
    end

    // Latch the accepted token for evaluation
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            held <= '0;
        end else if (hold_load) begin
            held <= in_op;
        end
    end

    // Stack storage; level alone marks which entries are live
    always_ff @(posedge Clock) begin
        if (push_en) begin
            stack[level[IW-1:0]] <= held;
        end
    end

endmodule
`default_nettype wire
